cmos_frame_source: RTL and testbench

Synthetic camera-side source for the edge-detection pipeline. It generates the `per_frame_vsync` / `per_frame_href` / `per_frame_clken` / `per_img_y` stream with programmable blanking, pixel throttling and selectable test patterns. It acts as the transmitter end of the pipeline input protocol and drives the Canny top in simulation and in on-board self-test, in place of a real CMOS sensor.

---
 rtl/cmos_frame_source.sv | 168 ++++++++++++++++
 tb/tb_cmos_frame_source.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_source.sv
// Synthetic CMOS sensor front end: emits a vsync/href/clken/pixel stream with
// programmable blanking, per-slot throttling and four selectable test patterns.
module cmos_frame_source #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 2,
    parameter int VBP_LINES   = 20,
    parameter int VFP_LINES   = 10,
    parameter int CLKEN_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_s,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  per_frame_vsync,
    output logic                  per_frame_href,
    output logic                  per_frame_clken,
    output logic [DATA_WIDTH-1:0] per_img_y,
    output logic                  frame_done
);
    localparam int LINE_LEN  = IMG_WIDTH + H_BLANK;
    localparam int XW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int MAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_B     = (IMG_HEIGHT > VFP_LINES) ? IMG_HEIGHT : VFP_LINES;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int DW        = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [XW-1:0]         x_q, x_d;
    logic [LW-1:0]         line_q, line_d;
    logic [1:0]            pat_q, pat_d;
    logic [DATA_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] fbase_q, fbase_d;
    logic                  vsync_q, vsync_d;
    logic                  href_q, href_d;
    logic                  clken_q, clken_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;

    logic tick, line_end, phase_end, frame_end;
    int   phase_lines;
    int   pix;

    always_comb begin
        case (state_q)
            S_VSYNC:  phase_lines = VSYNC_LINES;
            S_VBP:    phase_lines = VBP_LINES;
            S_ACTIVE: phase_lines = IMG_HEIGHT;
            S_VFP:    phase_lines = VFP_LINES;
            default:  phase_lines = 1;
        endcase
        tick      = (div_q == DW'(CLKEN_DIV - 1));
        line_end  = tick && (x_q == XW'(LINE_LEN - 1));
        phase_end = line_end && (int'(line_q) == phase_lines - 1);
        frame_end = (state_q == S_VFP) && phase_end;
    end

    // Counters only run outside IDLE; every phase change restarts the line count,
    // and a new frame latches the pattern and the post-increment frame count.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        x_d     = x_q;
        line_d  = line_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        fbase_d = fbase_q;
        if (state_q == S_IDLE) begin
            div_d  = '0;
            x_d    = '0;
            line_d = '0;
            if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
                fbase_d = fcnt_q;
            end
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                x_d = line_end ? '0 : x_q + 1'b1;
            end
            if (line_end) begin
                line_d = line_q + 1'b1;
            end
            if (phase_end) begin
                line_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBP;
                    S_VBP:    state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFP;
                    default:  state_d = S_IDLE;
                endcase
            end
            if (frame_end) begin
                fcnt_d = fcnt_q + 1'b1;
                if (enable) begin
                    state_d = S_VSYNC;
                    pat_d   = pattern_sel;
                    fbase_d = fcnt_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        vsync_d = (state_q == S_VSYNC);
        href_d  = (state_q == S_ACTIVE) && (int'(x_q) < IMG_WIDTH);
        clken_d = href_d && (div_q == '0);
        done_d  = frame_end;
        case (pat_q)
            2'd0:    pix = int'(x_q);
            2'd1:    pix = int'(line_q);
            2'd2:    pix = ((((int'(x_q) ^ int'(line_q)) >> 3) & 1) != 0) ? -1 : 0;
            default: pix = int'(x_q) + int'(line_q) + int'(fbase_q);
        endcase
        y_d = clken_d ? DATA_WIDTH'(pix) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            x_q     <= '0;
            line_q  <= '0;
            pat_q   <= '0;
            fcnt_q  <= '0;
            fbase_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            fcnt_q  <= fcnt_d;
            fbase_q <= fbase_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            clken_q <= clken_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    assign per_frame_vsync = vsync_q;
    assign per_frame_href  = href_q;
    assign per_frame_clken = clken_q;
    assign per_img_y       = y_q;
    assign frame_done      = done_q;
endmodule

// File: tb/tb_cmos_frame_source.sv
// Bench for cmos_frame_source: three instances (8 wide, 8 wide throttled by 3,
// 16 wide) share stimulus and are each compared to a frame-position model.
module tb_cmos_frame_source;
    logic       clk = 1'b0;
    logic       rst_s;
    logic       enable;
    logic [1:0] pattern_sel;

    logic       vs [3];
    logic       hr [3];
    logic       ck [3];
    logic       fd [3];
    logic [7:0] yy [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    cmos_frame_source #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4), .H_BLANK(4),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .CLKEN_DIV(1)) dutA (
        .clk(clk), .rst_s(rst_s), .enable(enable), .pattern_sel(pattern_sel),
        .per_frame_vsync(vs[0]), .per_frame_href(hr[0]), .per_frame_clken(ck[0]),
        .per_img_y(yy[0]), .frame_done(fd[0]));

    cmos_frame_source #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4), .H_BLANK(4),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .CLKEN_DIV(3)) dutB (
        .clk(clk), .rst_s(rst_s), .enable(enable), .pattern_sel(pattern_sel),
        .per_frame_vsync(vs[1]), .per_frame_href(hr[1]), .per_frame_clken(ck[1]),
        .per_img_y(yy[1]), .frame_done(fd[1]));

    cmos_frame_source #(.DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(4), .H_BLANK(4),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .CLKEN_DIV(1)) dutC (
        .clk(clk), .rst_s(rst_s), .enable(enable), .pattern_sel(pattern_sel),
        .per_frame_vsync(vs[2]), .per_frame_href(hr[2]), .per_frame_clken(ck[2]),
        .per_img_y(yy[2]), .frame_done(fd[2]));

    int W  [3] = '{8, 8, 16};
    int DV [3] = '{1, 3, 1};

    int mRun [3] = '{0, 0, 0};
    int mN   [3] = '{0, 0, 0};
    int mPat [3] = '{0, 0, 0};
    int mFc  [3] = '{0, 0, 0};
    int mCnt [3] = '{0, 0, 0};

    int   vsRise [3], vsCyc [3], hrRise [3], hrRun [3], lastRun [3];
    int   ckCnt [3], doneCnt [3], lastRise [3], spacing [3], lastDone [3];
    int   pixInFrame [3];
    logic pVs [3] = '{1'b0, 1'b0, 1'b0};
    logic pHr [3] = '{1'b0, 1'b0, 1'b0};
    int   firstPix [$];
    logic [7:0] cap [16];
    int   capN;

    logic [11:0] mExp, mAct;
    int   k, tf, pulseCyc;
    logic ren;

    typedef struct {
        int         len;
        logic [1:0] pat;
        int         fA;
        int         fB;
        int         fC;
    } vec_t;
    vec_t tbl [5];

    function automatic int frameLen(input int d);
        return 7 * DV[d] * (W[d] + 4);
    endfunction

    // Expected outputs at a given cycle of a frame, straight from the frame geometry.
    function automatic logic [11:0] frameOut(input int d, input int n, input int pat, input int fc);
        int lineCyc, line, w, slot, ph, row, y;
        logic v, h, c, dn;
        lineCyc = DV[d] * (W[d] + 4);
        line    = n / lineCyc;
        w       = n % lineCyc;
        slot    = w / DV[d];
        ph      = w % DV[d];
        row     = line - 2;
        v       = (line < 1);
        h       = (line >= 2) && (line < 6) && (slot < W[d]);
        c       = h && (ph == 0);
        case (pat)
            0:       y = slot;
            1:       y = row;
            2:       y = (((slot / 8) % 2) != ((row / 8) % 2)) ? 255 : 0;
            default: y = slot + row + fc;
        endcase
        y  = c ? (y % 256) : 0;
        dn = (n == frameLen(d) - 1);
        return {v, h, c, dn, 8'(y)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock of the reference: output for the current frame position, then advance.
    task automatic modelStep(input int d, output logic [11:0] e);
        if (rst_s)
            e = '0;
        else if (mRun[d] != 0)
            e = frameOut(d, mN[d], mPat[d], mFc[d]);
        else
            e = '0;
        if (rst_s) begin
            mRun[d] = 0; mN[d] = 0; mCnt[d] = 0;
        end else if (mRun[d] == 0) begin
            if (enable) begin
                mRun[d] = 1; mN[d] = 0; mPat[d] = int'(pattern_sel); mFc[d] = mCnt[d];
            end
        end else if (mN[d] == frameLen(d) - 1) begin
            mCnt[d] = (mCnt[d] + 1) % 256;
            if (enable) begin
                mN[d] = 0; mPat[d] = int'(pattern_sel); mFc[d] = mCnt[d];
            end else begin
                mRun[d] = 0;
            end
        end else begin
            mN[d] = mN[d] + 1;
        end
    endtask

    task automatic updateStats(input int d);
        if (vs[d] && !pVs[d]) begin
            vsRise[d]++;
            if (lastRise[d] >= 0) spacing[d] = cyc - lastRise[d];
            lastRise[d]   = cyc;
            pixInFrame[d] = 0;
        end
        if (vs[d]) vsCyc[d]++;
        if (hr[d] && !pHr[d]) begin
            hrRise[d]++;
            hrRun[d] = 0;
        end
        if (hr[d]) hrRun[d]++;
        if (!hr[d] && pHr[d]) lastRun[d] = hrRun[d];
        if (ck[d]) begin
            ckCnt[d]++;
            if (d == 0 && pixInFrame[d] == 0) firstPix.push_back(int'(yy[d]));
            pixInFrame[d]++;
            if (d == 2 && capN < 16) begin
                cap[capN] = yy[d];
                capN++;
            end
        end
        if (fd[d]) begin
            doneCnt[d]++;
            lastDone[d] = cyc;
        end
        pVs[d] = vs[d];
        pHr[d] = hr[d];
    endtask

    task automatic resetStats();
        for (int d = 0; d < 3; d++) begin
            vsRise[d] = 0; vsCyc[d] = 0; hrRise[d] = 0; hrRun[d] = 0; lastRun[d] = 0;
            ckCnt[d] = 0; doneCnt[d] = 0; lastRise[d] = -1; spacing[d] = 0;
            lastDone[d] = -1; pixInFrame[d] = 0;
        end
        firstPix.delete();
        capN = 0;
    endtask

    // Inputs change just after the falling edge, so each value is seen by `cycles` rising edges.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] p, input int cycles);
        rst_s       = r;
        enable      = e;
        pattern_sel = p;
        repeat (cycles) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int framesOf(input vec_t v, input int d);
        return (d == 0) ? v.fA : ((d == 1) ? v.fB : v.fC);
    endfunction

    // Every falling edge: compare each instance to its reference stream.
    initial begin
        resetStats();
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 3; d++) begin
                modelStep(d, mExp);
                mAct = {vs[d], hr[d], ck[d], fd[d], yy[d]};
                checkOutput($sformatf("dut%0d stream", d), 32'(mAct), 32'(mExp));
                updateStats(d);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{len: 1,   pat: 2'd0, fA: 1, fB: 1, fC: 1};
        tbl[1] = '{len: 84,  pat: 2'd1, fA: 1, fB: 1, fC: 1};
        tbl[2] = '{len: 85,  pat: 2'd2, fA: 2, fB: 1, fC: 1};
        tbl[3] = '{len: 200, pat: 2'd3, fA: 3, fB: 1, fC: 2};
        tbl[4] = '{len: 300, pat: 2'd0, fA: 4, fB: 2, fC: 3};

        rst_s = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
        @(negedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 2'd0, 2);

        $display("[TB] reset and idle");
        resetStats();
        applyStimulus(1'b0, 1'b0, 2'd0, 50);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("idle vsync rises dut%0d", d), vsRise[d], 0);
            checkOutput($sformatf("idle clken dut%0d", d), ckCnt[d], 0);
        end

        $display("[TB] single frame from one-cycle enable");
        resetStats();
        pulseCyc = cyc;
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 300);
        checkOutput("start latency", lastRise[0] - pulseCyc, 2);
        checkOutput("vsync high cycles", vsCyc[0], 12);
        checkOutput("frame_done position", lastDone[0] - lastRise[0], 83);
        checkOutput("single frame done", doneCnt[0], 1);

        $display("[TB] table of enable lengths");
        for (int i = 0; i < 5; i++) begin
            resetStats();
            applyStimulus(1'b0, 1'b1, tbl[i].pat, tbl[i].len);
            applyStimulus(1'b0, 1'b0, tbl[i].pat, 300);
            for (int d = 0; d < 3; d++) begin
                tf = framesOf(tbl[i], d);
                checkOutput($sformatf("v%0d dut%0d frame_done count", i, d), doneCnt[d], tf);
                checkOutput($sformatf("v%0d dut%0d href rises", i, d), hrRise[d], 4 * tf);
                checkOutput($sformatf("v%0d dut%0d clken count", i, d), ckCnt[d], 4 * W[d] * tf);
                checkOutput($sformatf("v%0d dut%0d vsync cycles", i, d), vsCyc[d], tf * DV[d] * (W[d] + 4));
                checkOutput($sformatf("v%0d dut%0d href length", i, d), lastRun[d], DV[d] * W[d]);
                if (tf >= 2)
                    checkOutput($sformatf("v%0d dut%0d vsync spacing", i, d), spacing[d], frameLen(d));
            end
        end

        $display("[TB] continuous run with frame-count pattern");
        applyStimulus(1'b1, 1'b0, 2'd3, 2);
        resetStats();
        applyStimulus(1'b0, 1'b1, 2'd3, 200);
        applyStimulus(1'b0, 1'b0, 2'd3, 300);
        checkOutput("continuous frames", doneCnt[0], 3);
        checkOutput("continuous spacing", spacing[0], 84);
        checkOutput("first pixel count", firstPix.size(), 3);
        for (int i = 0; i < firstPix.size(); i++)
            checkOutput($sformatf("first pixel frame %0d", i), firstPix[i], i);

        $display("[TB] checkerboard row 0");
        applyStimulus(1'b1, 1'b0, 2'd2, 2);
        resetStats();
        applyStimulus(1'b0, 1'b1, 2'd2, 1);
        applyStimulus(1'b0, 1'b0, 2'd2, 200);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("checker x=%0d", i), cap[i], (i < 8) ? 0 : 255);

        $display("[TB] reset mid-line");
        resetStats();
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        k = 0;
        while (hr[0] !== 1'b1 && k < 100) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1);
            k++;
        end
        checkOutput("reached href before reset", hr[0], 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 3);
        applyStimulus(1'b1, 1'b0, 2'd0, 1);
        for (int d = 0; d < 3; d++)
            checkOutput($sformatf("post-reset outputs dut%0d", d), {vs[d], hr[d], ck[d], fd[d], yy[d]}, 0);
        resetStats();
        applyStimulus(1'b0, 1'b0, 2'd0, 100);
        for (int d = 0; d < 3; d++)
            checkOutput($sformatf("no restart dut%0d", d), vsRise[d], 0);

        $display("[TB] mid-frame enable drop and pattern change");
        applyStimulus(1'b1, 1'b0, 2'd1, 2);
        resetStats();
        applyStimulus(1'b0, 1'b1, 2'd1, 15);
        k = 0;
        while (hr[0] !== 1'b1 && k < 100) begin
            applyStimulus(1'b0, 1'b0, 2'd1, 1);
            k++;
        end
        checkOutput("reached href before pattern change", hr[0], 1);
        applyStimulus(1'b0, 1'b0, 2'd3, 400);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("frame completes dut%0d", d), doneCnt[d], 1);
            checkOutput($sformatf("full frame clken dut%0d", d), ckCnt[d], 4 * W[d]);
        end

        $display("[TB] randomized run");
        applyStimulus(1'b1, 1'b0, 2'd0, 2);
        ren = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ren = ~ren;
            applyStimulus(($urandom_range(0, 299) == 0), ren, 2'($urandom_range(0, 3)), 1);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
